// File: rtl/io_port_bridge.sv
// Peripheral-side bridge for a processor I/O interface: a show-ahead input FIFO
// feeding io_in, and per-port holding registers presenting io_out downstream.
module io_port_bridge #(
    parameter int NUBITS = 32,
    parameter int NUIOOU = 2,
    parameter int FDEPTH = 16,
    parameter int ITRTHR = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUBITS-1:0]        src_dat,
    input  logic                     src_vld,
    output logic                     src_rdy,
    output logic [NUBITS-1:0]        io_in,
    input  logic                     req_in,
    input  logic [NUBITS-1:0]        io_out,
    input  logic [NUIOOU-1:0]        out_en,
    output logic [NUIOOU*NUBITS-1:0] snk_dat,
    output logic [NUIOOU-1:0]        snk_vld,
    input  logic [NUIOOU-1:0]        snk_rdy,
    output logic                     itr,
    output logic [$clog2(FDEPTH):0]  fifo_cnt,
    output logic                     udf,
    output logic [NUIOOU-1:0]        ovf,
    input  logic                     clr_err
);

    localparam int AW = $clog2(FDEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FDEPTH);
    localparam logic [CW-1:0] THR_CNT  = CW'(ITRTHR);

    logic [NUBITS-1:0] mem [FDEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     cnt_reg;
    logic [CW-1:0]     cnt_next;
    logic              itr_reg;
    logic              udf_reg;
    logic              push;
    logic              pop;
    logic              empty;

    assign empty    = (cnt_reg == '0);
    assign src_rdy  = (cnt_reg != FULL_CNT);
    assign push     = src_vld & src_rdy;
    // Popping is gated on the current occupancy only, so a word pushed in the
    // same cycle as an empty-FIFO read is never bypassed to the processor.
    assign pop      = req_in & ~empty;
    assign io_in    = empty ? '0 : mem[rd_ptr_reg];
    assign fifo_cnt = cnt_reg;
    assign itr      = itr_reg;
    assign udf      = udf_reg;

    always_comb begin
        cnt_next = cnt_reg;
        if (push && !pop) begin
            cnt_next = cnt_reg + 1'b1;
        end else if (pop && !push) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= src_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
            itr_reg    <= 1'b0;
            udf_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            cnt_reg <= cnt_next;
            // Fires only on the upward crossing of the threshold.
            itr_reg <= (cnt_reg < THR_CNT) && (cnt_next >= THR_CNT);
            if (req_in && empty) begin
                udf_reg <= 1'b1;
            end else if (clr_err) begin
                udf_reg <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < NUIOOU; gi++) begin : g_port
        logic [NUBITS-1:0] dat_reg;
        logic              vld_reg;
        logic              ovf_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dat_reg <= '0;
                vld_reg <= 1'b0;
                ovf_reg <= 1'b0;
            end else begin
                if (out_en[gi]) begin
                    dat_reg <= io_out;
                    vld_reg <= 1'b1;
                end else if (snk_rdy[gi]) begin
                    vld_reg <= 1'b0;
                end
                // A load onto an unconsumed word loses that word.
                if (out_en[gi] && vld_reg && !snk_rdy[gi]) begin
                    ovf_reg <= 1'b1;
                end else if (clr_err) begin
                    ovf_reg <= 1'b0;
                end
            end
        end

        assign snk_dat[gi*NUBITS +: NUBITS] = dat_reg;
        assign snk_vld[gi]                  = vld_reg;
        assign ovf[gi]                      = ovf_reg;
    end

endmodule

// File: tb/tb_io_port_bridge.sv
// Bench for io_port_bridge: directed scenarios plus random traffic, all checked
// against a queue-based behavioural model of the FIFO, interrupt and ports.
module tb_io_port_bridge;

    localparam int W   = 32;
    localparam int NP  = 2;
    localparam int DEP = 16;
    localparam int THR = 4;

    logic            clk;
    logic            rst;
    logic [W-1:0]    src_dat;
    logic            src_vld;
    logic            src_rdy;
    logic [W-1:0]    io_in;
    logic            req_in;
    logic [W-1:0]    io_out;
    logic [NP-1:0]   out_en;
    logic [NP*W-1:0] snk_dat;
    logic [NP-1:0]   snk_vld;
    logic [NP-1:0]   snk_rdy;
    logic            itr;
    logic [4:0]      fifo_cnt;
    logic            udf;
    logic [NP-1:0]   ovf;
    logic            clr_err;

    io_port_bridge #(.NUBITS(W), .NUIOOU(NP), .FDEPTH(DEP), .ITRTHR(THR)) dut (
        .clk(clk), .rst(rst),
        .src_dat(src_dat), .src_vld(src_vld), .src_rdy(src_rdy),
        .io_in(io_in), .req_in(req_in),
        .io_out(io_out), .out_en(out_en),
        .snk_dat(snk_dat), .snk_vld(snk_vld), .snk_rdy(snk_rdy),
        .itr(itr), .fifo_cnt(fifo_cnt), .udf(udf), .ovf(ovf), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [W-1:0] q[$];
    logic         m_itr;
    logic         m_udf;
    logic [W-1:0] m_dat [NP];
    logic         m_vld [NP];
    logic         m_ovf [NP];
    logic [W-1:0] exp_io_in;
    logic [W-1:0] seen_io_in;
    logic         exp_src_rdy;
    logic         seen_src_rdy;

    task automatic model_reset();
        q.delete();
        m_itr = 1'b0;
        m_udf = 1'b0;
        for (int k = 0; k < NP; k++) begin
            m_dat[k] = '0;
            m_vld[k] = 1'b0;
            m_ovf[k] = 1'b0;
        end
    endtask

    // One clock of stimulus; observes pre-edge io_in/src_rdy and advances the model.
    task automatic tick(input logic sv, input logic [W-1:0] sd, input logic rq,
                        input logic [NP-1:0] oe, input logic [W-1:0] io,
                        input logic [NP-1:0] sr, input logic ce);
        int c;
        @(negedge clk);
        src_vld = sv; src_dat = sd; req_in = rq;
        out_en = oe; io_out = io; snk_rdy = sr; clr_err = ce;
        #1;
        seen_io_in   = io_in;
        seen_src_rdy = src_rdy;
        c = q.size();
        exp_io_in   = (c > 0) ? q[0] : '0;
        exp_src_rdy = (c != DEP);
        if (rq && c > 0) void'(q.pop_front());
        if (sv && c != DEP) q.push_back(sd);
        m_itr = (c < THR) && (q.size() >= THR);
        if (rq && c == 0) m_udf = 1'b1;
        else if (ce)      m_udf = 1'b0;
        for (int k = 0; k < NP; k++) begin
            if (oe[k] && m_vld[k] && !sr[k]) m_ovf[k] = 1'b1;
            else if (ce)                     m_ovf[k] = 1'b0;
            if (oe[k]) begin
                m_dat[k] = io;
                m_vld[k] = 1'b1;
            end else if (sr[k]) begin
                m_vld[k] = 1'b0;
            end
        end
        $display("txn t=%0t vld=%b dat=%h req=%b oe=%b io=%h rdy=%b clr=%b io_in=%h cnt=%0d",
                 $time, sv, sd, rq, oe, io, sr, ce, seen_io_in, q.size());
        @(posedge clk);
        #1;
        src_vld = 1'b0; req_in = 1'b0; out_en = '0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        src_vld = 0; src_dat = 0; req_in = 0; io_out = 0; out_en = 0; snk_rdy = 0; clr_err = 0;
        model_reset();
        #1;
        n_cmp++; if (fifo_cnt !== 5'd0) begin n_bad++; $display("FAIL rst_cnt got=%0d exp=0", fifo_cnt); end
        n_cmp++; if (src_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_src_rdy got=%b exp=1", src_rdy); end
        n_cmp++; if (io_in !== '0) begin n_bad++; $display("FAIL rst_io_in got=%h exp=0", io_in); end
        n_cmp++; if ({itr, udf, ovf, snk_vld} !== '0) begin n_bad++;
            $display("FAIL rst_flags got itr=%b udf=%b ovf=%b vld=%b exp=0", itr, udf, ovf, snk_vld); end
        n_cmp++; if (snk_dat !== '0) begin n_bad++; $display("FAIL rst_snk_dat got=%h exp=0", snk_dat); end
        @(negedge clk); rst = 1'b0;
        // Mid-stream asynchronous reset
        for (int i = 0; i < 3; i++) tick(1, $urandom, 0, 2'b01, $urandom, 2'b00, 0);
        n_cmp++; if (fifo_cnt !== 5'd3) begin n_bad++; $display("FAIL pre_rst_cnt got=%0d exp=3", fifo_cnt); end
        #2; rst = 1'b1; #1;
        n_cmp++; if (io_in !== '0) begin n_bad++; $display("FAIL async_io_in got=%h exp=0", io_in); end
        n_cmp++; if (fifo_cnt !== 5'd0) begin n_bad++; $display("FAIL async_cnt got=%0d exp=0", fifo_cnt); end
        n_cmp++; if (snk_vld !== 2'b00) begin n_bad++; $display("FAIL async_snk_vld got=%b exp=00", snk_vld); end
        n_cmp++; if (src_rdy !== 1'b1) begin n_bad++; $display("FAIL async_src_rdy got=%b exp=1", src_rdy); end
        model_reset();
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEP; i++) begin
            tick(1, W'(32'h11 + i), 0, 2'b00, 0, 2'b00, 0);
            n_cmp++; if (fifo_cnt !== 5'(i + 1)) begin n_bad++;
                $display("FAIL fill_cnt got=%0d exp=%0d", fifo_cnt, i + 1); end
            n_cmp++; if (src_rdy !== (i != DEP - 1)) begin n_bad++;
                $display("FAIL fill_src_rdy got=%b exp=%b", src_rdy, (i != DEP - 1)); end
        end
        for (int i = 0; i < DEP; i++) begin
            tick(0, 0, 1, 2'b00, 0, 2'b00, 0);
            n_cmp++; if (seen_io_in !== W'(32'h11 + i)) begin n_bad++;
                $display("FAIL drain_io_in got=%h exp=%h", seen_io_in, 32'h11 + i); end
        end
        n_cmp++; if (fifo_cnt !== 5'd0) begin n_bad++; $display("FAIL drain_cnt got=%0d exp=0", fifo_cnt); end
        n_cmp++; if (udf !== 1'b0) begin n_bad++; $display("FAIL drain_udf got=%b exp=0", udf); end
    endtask

    task automatic test_underflow();
        tick(1, 32'hAA, 1, 2'b00, 0, 2'b00, 0);
        n_cmp++; if (seen_io_in !== '0) begin n_bad++; $display("FAIL udf_io_in got=%h exp=0", seen_io_in); end
        n_cmp++; if (udf !== 1'b1) begin n_bad++; $display("FAIL udf_set got=%b exp=1", udf); end
        n_cmp++; if (io_in !== 32'hAA) begin n_bad++; $display("FAIL udf_head got=%h exp=aa", io_in); end
        n_cmp++; if (fifo_cnt !== 5'd1) begin n_bad++; $display("FAIL udf_cnt got=%0d exp=1", fifo_cnt); end
        tick(0, 0, 0, 2'b00, 0, 2'b00, 1);
        n_cmp++; if (udf !== 1'b0) begin n_bad++; $display("FAIL udf_clr got=%b exp=0", udf); end
        tick(0, 0, 1, 2'b00, 0, 2'b00, 0);
        n_cmp++; if (seen_io_in !== 32'hAA) begin n_bad++; $display("FAIL udf_pop got=%h exp=aa", seen_io_in); end
    endtask

    task automatic test_itr();
        for (int i = 0; i < 5; i++) begin
            tick(1, $urandom, 0, 2'b00, 0, 2'b00, 0);
            n_cmp++; if (itr !== (i == 3)) begin n_bad++;
                $display("FAIL itr_fill%0d got=%b exp=%b", i, itr, (i == 3)); end
        end
        for (int i = 0; i < 2; i++) begin
            tick(0, 0, 1, 2'b00, 0, 2'b00, 0);
            n_cmp++; if (itr !== 1'b0) begin n_bad++; $display("FAIL itr_pop got=%b exp=0", itr); end
        end
        tick(1, $urandom, 0, 2'b00, 0, 2'b00, 0);
        n_cmp++; if (itr !== 1'b1) begin n_bad++; $display("FAIL itr_refire got=%b exp=1", itr); end
        tick(0, 0, 0, 2'b00, 0, 2'b00, 0);
        n_cmp++; if (itr !== 1'b0) begin n_bad++; $display("FAIL itr_width got=%b exp=0", itr); end
        while (q.size() > 0) tick(0, 0, 1, 2'b00, 0, 2'b00, 0);
    endtask

    task automatic test_output();
        tick(0, 0, 0, 2'b01, 32'h12345678, 2'b00, 0);
        n_cmp++; if (snk_vld[0] !== 1'b1 || snk_dat[31:0] !== 32'h12345678) begin n_bad++;
            $display("FAIL out_load got vld=%b dat=%h exp vld=1 dat=12345678", snk_vld[0], snk_dat[31:0]); end
        tick(0, 0, 0, 2'b01, 32'h9, 2'b00, 0);
        n_cmp++; if (snk_dat[31:0] !== 32'h9) begin n_bad++;
            $display("FAIL out_overwrite got=%h exp=9", snk_dat[31:0]); end
        n_cmp++; if (ovf !== 2'b01) begin n_bad++; $display("FAIL out_ovf got=%b exp=01", ovf); end
        tick(0, 0, 0, 2'b00, 0, 2'b01, 1);
        n_cmp++; if (snk_vld[0] !== 1'b0 || snk_dat[31:0] !== 32'h9 || ovf !== 2'b00) begin n_bad++;
            $display("FAIL out_consume got vld=%b dat=%h ovf=%b exp vld=0 dat=9 ovf=00",
                     snk_vld[0], snk_dat[31:0], ovf); end
    endtask

    task automatic test_back_to_back();
        tick(0, 0, 0, 2'b10, 32'h33, 2'b00, 0);
        tick(0, 0, 0, 2'b10, 32'h55, 2'b10, 0);
        n_cmp++; if (snk_vld[1] !== 1'b1 || snk_dat[63:32] !== 32'h55 || ovf[1] !== 1'b0) begin n_bad++;
            $display("FAIL b2b_port1 got vld=%b dat=%h ovf=%b exp vld=1 dat=55 ovf=0",
                     snk_vld[1], snk_dat[63:32], ovf[1]); end
        tick(0, 0, 0, 2'b00, 0, 2'b10, 0);
        n_cmp++; if (snk_vld[1] !== 1'b0) begin n_bad++; $display("FAIL b2b_drop got=%b exp=0", snk_vld[1]); end
        // Pointer wrap: steady push/pop at occupancy 8
        for (int i = 0; i < 8; i++) tick(1, $urandom, 0, 2'b00, 0, 2'b00, 0);
        for (int i = 0; i < 40; i++) begin
            tick(1, $urandom, 1, 2'b00, 0, 2'b00, 0);
            n_cmp++; if (seen_io_in !== exp_io_in) begin n_bad++;
                $display("FAIL wrap_io_in%0d got=%h exp=%h", i, seen_io_in, exp_io_in); end
            n_cmp++; if (fifo_cnt !== 5'd8) begin n_bad++; $display("FAIL wrap_cnt got=%0d exp=8", fifo_cnt); end
        end
        while (q.size() > 0) begin
            tick(0, 0, 1, 2'b00, 0, 2'b00, 0);
            n_cmp++; if (seen_io_in !== exp_io_in) begin n_bad++;
                $display("FAIL wrap_drain got=%h exp=%h", seen_io_in, exp_io_in); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) == 0),
                 NP'($urandom_range(0, 3)), $urandom, NP'($urandom_range(0, 3)),
                 ($urandom_range(0, 15) == 0));
            n_cmp++; if (seen_io_in !== exp_io_in || seen_src_rdy !== exp_src_rdy) begin n_bad++;
                $display("FAIL rnd_fifo_head%0d got io_in=%h rdy=%b exp io_in=%h rdy=%b",
                         i, seen_io_in, seen_src_rdy, exp_io_in, exp_src_rdy); end
            n_cmp++; if (fifo_cnt !== 5'(q.size()) || itr !== m_itr || udf !== m_udf) begin n_bad++;
                $display("FAIL rnd_state%0d got cnt=%0d itr=%b udf=%b exp cnt=%0d itr=%b udf=%b",
                         i, fifo_cnt, itr, udf, q.size(), m_itr, m_udf); end
            for (int k = 0; k < NP; k++) begin
                n_cmp++;
                if (snk_vld[k] !== m_vld[k] || snk_dat[k*W +: W] !== m_dat[k] || ovf[k] !== m_ovf[k]) begin
                    n_bad++;
                    $display("FAIL rnd_port%0d_%0d got vld=%b dat=%h ovf=%b exp vld=%b dat=%h ovf=%b",
                             k, i, snk_vld[k], snk_dat[k*W +: W], ovf[k], m_vld[k], m_dat[k], m_ovf[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_underflow();
        test_itr();
        test_output();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
